// File: rtl/fir_tx_sequencer.sv
// Timing and FILL/RUN/DRAIN sequencing for the polyphase FIR pulse-shaper.
// Every output is decoded from registered state, so no input reaches an output combinationally.
module fir_tx_sequencer #(
    parameter int OVER_SAMP = 8,
    parameter int N_BAUDS   = 7,
    parameter int NB_COUNT  = 3,
    parameter int NB_DIV    = 4,
    parameter int NB_SYM    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [NB_DIV-1:0]   i_clk_div,
    output logic                o_enable,
    output logic                o_sym_valid,
    output logic [NB_COUNT-1:0] o_phase,
    output logic                o_prbs_step,
    output logic                o_drain,
    output logic                o_out_valid,
    output logic                o_busy
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    localparam logic [NB_COUNT-1:0] PH_LAST  = NB_COUNT'(OVER_SAMP - 1);
    localparam logic [NB_SYM-1:0]   SYM_LAST = NB_SYM'(N_BAUDS - 2);

    state_t              state_q, state_d;
    logic [NB_DIV-1:0]   div_cnt_q, div_cnt_d;
    logic [NB_DIV-1:0]   div_q, div_d;
    logic [NB_COUNT-1:0] phase_q, phase_d;
    logic [NB_SYM-1:0]   sym_cnt_q, sym_cnt_d;
    logic                stop_pend_q, stop_pend_d;

    logic tick, end_sym, stop_eff;

    assign tick     = (state_q != IDLE) && (div_cnt_q == div_q);
    assign end_sym  = tick && (phase_q == PH_LAST);
    // a stop arriving on the end_sym cycle itself is honoured at that same edge
    assign stop_eff = stop_pend_q || (i_stop && (state_q == FILL || state_q == RUN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            div_q       <= '0;
            phase_q     <= '0;
            sym_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            sym_cnt_q   <= sym_cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        div_d       = div_q;
        phase_d     = phase_q;
        sym_cnt_d   = sym_cnt_q;
        stop_pend_d = stop_pend_q;
        if (state_q == IDLE) begin
            if (i_start) begin
                div_d       = i_clk_div;
                div_cnt_d   = '0;
                phase_d     = '0;
                sym_cnt_d   = '0;
                stop_pend_d = 1'b0;
                state_d     = FILL;
            end
        end else begin
            div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            stop_pend_d = stop_eff && (state_q != DRAIN);
            case (state_q)
                FILL: if (end_sym) begin
                    if (stop_eff) begin
                        // abort before any output has become valid
                        state_d     = IDLE;
                        sym_cnt_d   = '0;
                        stop_pend_d = 1'b0;
                    end else if (sym_cnt_q == SYM_LAST) begin
                        state_d   = RUN;
                        sym_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
                RUN: if (end_sym && stop_eff) begin
                    state_d     = DRAIN;
                    sym_cnt_d   = '0;
                    stop_pend_d = 1'b0;
                end
                DRAIN: if (end_sym) begin
                    if (sym_cnt_q == SYM_LAST) begin
                        state_d   = IDLE;
                        sym_cnt_d = '0;
                        div_cnt_d = '0;
                        phase_d   = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_enable    = tick;
        o_sym_valid = tick && (phase_q == '0);
        o_phase     = phase_q;
        o_prbs_step = tick && (phase_q == '0) && (state_q != DRAIN);
        o_drain     = (state_q == DRAIN);
        o_out_valid = tick && (state_q == RUN || state_q == DRAIN);
        o_busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_fir_tx_sequencer.sv
// Bench for fir_tx_sequencer: directed bursts then random traffic, checked every cycle
// against a model that tracks a burst as a cycle count plus the symbol at which stop landed.
module tb_fir_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic [3:0] i_clk_div = '0;
    logic       o_enable, o_sym_valid, o_prbs_step, o_drain, o_out_valid, o_busy;
    logic [2:0] o_phase;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int drain_ov = 0;

    // model: burst active, cycles since burst start, sample period-1, stop symbol (-1 none)
    int m_busy = 0;
    int m_c = 0;
    int m_p = 0;
    int m_ss = -1;

    always #5 clk = ~clk;

    fir_tx_sequencer dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_clk_div(i_clk_div),
        .o_enable(o_enable), .o_sym_valid(o_sym_valid), .o_phase(o_phase),
        .o_prbs_step(o_prbs_step), .o_drain(o_drain), .o_out_valid(o_out_valid), .o_busy(o_busy)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // 0 = FILL, 1 = RUN, 2 = DRAIN for symbol s of the current burst
    function automatic int mode_of(input int s);
        if (s < 6) return 0;
        if (m_ss >= 6 && s > m_ss) return 2;
        return 1;
    endfunction

    function automatic int last_sym();
        if (m_ss < 0) return 1 << 30;
        return (m_ss < 6) ? m_ss : m_ss + 6;
    endfunction

    // packed {enable, sym_valid, phase[2:0], prbs_step, drain, out_valid, busy}
    function automatic logic [8:0] model_out();
        int k, s, md;
        logic tk;
        logic [2:0] ph;
        logic sv;
        if (m_busy == 0) return '0;
        k  = m_c / (m_p + 1);
        tk = ((m_c % (m_p + 1)) == m_p);
        ph = 3'(k % 8);
        s  = k / 8;
        md = mode_of(s);
        sv = tk && (ph == 3'd0);
        return {tk, sv, ph, sv && (md != 2), md == 2, tk && (md != 0), 1'b1};
    endfunction

    task automatic model_next(input logic r, input logic st, input logic sp, input logic [3:0] d);
        int k, s;
        logic tk;
        if (r) begin
            m_busy = 0;
        end else if (m_busy == 0) begin
            if (st) begin
                m_busy = 1; m_c = 0; m_p = int'(d); m_ss = -1;
            end
        end else begin
            k  = m_c / (m_p + 1);
            tk = ((m_c % (m_p + 1)) == m_p);
            s  = k / 8;
            if (sp && m_ss < 0) m_ss = s;
            if (tk && (k % 8) == 7 && s == last_sym()) m_busy = 0;
            else m_c++;
        end
    endtask

    task automatic step(input logic r, input logic st, input logic sp, input logic [3:0] d);
        @(negedge clk);
        chk("outs", {7'd0, o_enable, o_sym_valid, o_phase, o_prbs_step, o_drain, o_out_valid, o_busy},
            {7'd0, model_out()});
        if (o_drain && o_out_valid) drain_ov++;
        rst = r; i_start = st; i_stop = sp; i_clk_div = d;
        model_next(r, st, sp, d);
        cyc++;
    endtask

    initial begin
        // reset held, then long idle with inputs low
        repeat (3) step(1'b1, 1'b0, 1'b0, 4'd0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 4'd0);

        // div 0 burst, stop during RUN at phase 3, full drain
        drain_ov = 0;
        step(1'b0, 1'b1, 1'b0, 4'd0);
        repeat (51) step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd0);
        repeat (70) step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("drain_ov", 16'(drain_ov), 16'd48);
        chk("idle_after_drain", {15'd0, o_busy}, 16'd0);

        // div 3 burst, stop in the second FILL symbol
        step(1'b0, 1'b1, 1'b0, 4'd3);
        repeat (42) step(1'b0, 1'b0, 1'b0, 4'd3);
        step(1'b0, 1'b0, 1'b1, 4'd3);
        repeat (40) step(1'b0, 1'b0, 1'b0, 4'd3);

        // div 1 burst with start held and div wandering, then rst mid-drain
        step(1'b0, 1'b1, 1'b0, 4'd1);
        repeat (110) step(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)));
        step(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)));
        repeat (40) step(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
        step(1'b1, 1'b0, 1'b0, 4'd0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 4'd0);

        // random traffic
        for (int i = 0; i < 8000; i++) begin
            step(1'($urandom_range(0, 1499) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 199) == 0), 4'($urandom_range(0, 3)));
        end
        step(1'b0, 1'b0, 1'b0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_tx_sequencer.md
Name: fir_tx_sequencer

Overview:
Controller that sequences the polyphase FIR pulse-shaping filter in the modulator transmit path. It derives the sample-rate enable, the baud-rate symbol strobe and the polyphase index from clk, and steps the PRBS source. A FILL/RUN/DRAIN state machine gates output-valid so downstream logic sees only fully populated filter outputs, and every transmitted symbol is flushed completely on stop. It sits between top-level start/stop control and the prbs/fir_filter pair.

Parameters:
OVER_SAMP, 8, samples per symbol; must be a power of two
N_BAUDS, 7, filter span in symbols (shift-register depth)
NB_COUNT, 3, phase counter width, log2(OVER_SAMP)
NB_DIV, 4, clock-divider width
NB_SYM, 3, symbol counter width; must hold N_BAUDS-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
i_start  in  1  start request; sampled only in IDLE
i_stop  in  1  stop request; sticky until acted on
i_clk_div  in  NB_DIV  sample period minus 1, in clk cycles; latched on start
o_enable  out  1  sample tick to filter i_enable
o_sym_valid  out  1  symbol shift strobe to filter i_valid
o_phase  out  NB_COUNT  polyphase index of current tick
o_prbs_step  out  1  advance PRBS generator
o_drain  out  1  datapath forces filter i_prbs to 0
o_out_valid  out  1  filter output is valid on this tick
o_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, FILL, RUN, DRAIN. All registers clear on rst: state=IDLE, div_cnt=0, div_q=0, phase=0, sym_cnt=0, stop_pend=0. With those values every output is 0.
- Outputs are decoded from registered state only; no combinational path from any input to any output.
- IDLE + i_start: div_q<=i_clk_div, div_cnt<=0, phase<=0, sym_cnt<=0, stop_pend<=0, state<=FILL. i_start in any other state is ignored.
- Tick: tick = (state!=IDLE) && (div_cnt==div_q); o_enable=tick. div_cnt increments each cycle when not IDLE and returns to 0 on tick. div_q=0 gives a tick every cycle.
- On tick, phase increments and wraps from OVER_SAMP-1 to 0. o_phase = phase.
- o_sym_valid = tick && phase==0, in FILL, RUN and DRAIN.
- o_prbs_step = o_sym_valid && state!=DRAIN.
- o_drain = (state==DRAIN).
- o_out_valid = tick && state in {RUN, DRAIN}.
- o_busy = (state!=IDLE).
- Symbol end: end_sym = tick && phase==OVER_SAMP-1.
- FILL: on end_sym, sym_cnt++. When sym_cnt reaches N_BAUDS-2 at end_sym, sym_cnt<=0 and state<=RUN. FILL therefore lasts (N_BAUDS-1)*OVER_SAMP ticks.
- Stop handling: i_stop sets stop_pend in FILL and RUN; it is ignored in IDLE and DRAIN. A stop is acted on only at end_sym.
  - RUN: go to DRAIN, sym_cnt<=0, clear stop_pend.
  - FILL: abort to IDLE, clear stop_pend. No o_out_valid is ever produced.
- An i_stop coinciding with an end_sym cycle takes effect at that same edge.
- In FILL, a stop at the end_sym that would otherwise enter RUN takes priority: go to IDLE.
- DRAIN: on end_sym, sym_cnt++. After N_BAUDS-1 symbol periods, go to IDLE, zeroing div_cnt and phase. This shifts the last data symbol through to tap N_BAUDS-1.
- Simultaneous i_start and i_stop in IDLE: start wins and stop is dropped.
- div_q is constant for the whole burst. Changes on i_clk_div outside IDLE have no effect.
- rst asserted in any state, mid-symbol: IDLE on the next edge, with no drain.

Test Plan:
- rst held 3 cycles, then released with inputs 0 -> all outputs 0 and o_busy=0 indefinitely.
- i_clk_div=0, i_start pulse at cycle 0 -> o_enable high every cycle from cycle 1. o_sym_valid and o_prbs_step on cycles 1, 9, 17, … o_phase runs 0..7 and wraps. First o_out_valid at cycle 49, with state=RUN.
- i_clk_div=3 -> o_enable every 4th cycle, first at cycle 4. The first o_sym_valid coincides with it. One symbol period is 32 cycles.
- i_clk_div=0, burst running in RUN, i_stop pulsed at phase 3 -> continues to the phase-7 tick, then o_drain=1. o_prbs_step stays 0 while o_sym_valid still fires. Exactly 48 further o_out_valid ticks, then o_busy=0.
- i_stop during FILL, second symbol -> IDLE after that symbol's phase-7 tick; o_out_valid never asserted.
- rst pulsed mid-DRAIN; i_start held high during RUN; i_clk_div changed mid-burst -> rst returns all outputs to 0 on the next cycle. The held i_start causes no restart. The tick period is unchanged by the new i_clk_div.
